// File: rtl/muldiv_if.sv
// Command/result bundle between the CPU pipeline and the HI/LO multiply-divide unit.
// The CPU drives commands through the master modport; the unit owns HI/LO and status.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] op_x;
    logic [WIDTH-1:0] op_y;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_zero;

    modport master (
        output start, op, op_x, op_y,
        input  busy, done, hi, lo, div_zero
    );

    modport slave (
        input  start, op, op_x, op_y,
        output busy, done, hi, lo, div_zero
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style HI/LO unit: radix-2 shift-add multiply, restoring divide,
// sign fix-up in a final FIX cycle, plus single-cycle MTHI/MTLO.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic    clk,
    input logic    rst_n,
    muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] y_mag;
    logic [WIDTH-1:0] x_raw;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;
    logic             y_zero;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             done_r;
    logic             dz_r;

    logic             accept;
    logic             op_mul;
    logic             op_div;
    logic             op_signed;
    logic             x_neg;
    logic             y_neg;
    logic [WIDTH-1:0] x_mag;
    logic [WIDTH-1:0] y_mag_in;
    logic             last_iter;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign accept    = bus.start && (state == S_IDLE);
    assign op_mul    = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
    assign op_div    = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    assign op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign last_iter = (cnt == CW'(WIDTH - 1));

    // Operand magnitudes: signed ops iterate on |x|, |y| and restore signs in FIX.
    always_comb begin
        x_neg    = op_signed && bus.op_x[WIDTH-1];
        y_neg    = op_signed && bus.op_y[WIDTH-1];
        x_mag    = x_neg ? -bus.op_x : bus.op_x;
        y_mag_in = y_neg ? -bus.op_y : bus.op_y;
    end

    // One iteration step of each algorithm, plus the sign-corrected final results.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, y_mag} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, y_mag};
        prod      = {acc_hi, acc_lo};
        prod_fix  = neg_q ? -prod : prod;
        quo_fix   = neg_q ? -acc_lo : acc_lo;
        rem_fix   = neg_r ? -acc_hi : acc_hi;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (bus.start && op_mul) begin
                    state_nxt = S_MUL;
                end else if (bus.start && op_div) begin
                    state_nxt = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (last_iter) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        bus.busy     = (state != S_IDLE);
        bus.done     = done_r;
        bus.hi       = hi_r;
        bus.lo       = lo_r;
        bus.div_zero = dz_r;
    end

    // Datapath and architectural HI/LO; HI/LO only change at E0 (moves) or in FIX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            y_mag  <= '0;
            x_raw  <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            y_zero <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
            done_r <= 1'b0;
            dz_r   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values, independent of statement order.
            done_r <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        dz_r   <= 1'b0;
                        cnt    <= '0;
                        acc_hi <= '0;
                        acc_lo <= x_mag;
                        y_mag  <= y_mag_in;
                        x_raw  <= bus.op_x;
                        is_div <= op_div;
                        neg_q  <= x_neg ^ y_neg;
                        neg_r  <= x_neg;
                        y_zero <= (bus.op_y == '0);
                        if (bus.op == OP_MTHI) begin
                            hi_r   <= bus.op_x;
                            done_r <= 1'b1;
                        end else if (bus.op == OP_MTLO) begin
                            lo_r   <= bus.op_x;
                            done_r <= 1'b1;
                        end else if (!op_mul && !op_div) begin
                            done_r <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    cnt              <= cnt + CW'(1);
                    {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
                end
                S_DIV: begin
                    cnt <= cnt + CW'(1);
                    if (!div_diff[WIDTH]) begin
                        acc_hi <= div_diff[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi <= div_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                    end
                end
                S_FIX: begin
                    done_r <= 1'b1;
                    if (!is_div) begin
                        {hi_r, lo_r} <= prod_fix;
                    end else if (y_zero) begin
                        lo_r <= '1;
                        hi_r <= x_raw;
                        dz_r <= 1'b1;
                    end else begin
                        lo_r <= quo_fix;
                        hi_r <= rem_fix;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a reference model pushes expected HI/LO/div_zero
// into a scoreboard at issue time, and a monitor pops and compares on every done pulse.
module tb_muldiv_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t         sb[$];
    exp_t         e_pop;
    int           n_tests = 0;
    int           n_fail  = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic         m_dz = 1'b0;
    int           lat;
    int           bcnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: native wide arithmetic, C-style truncating division.
    function automatic void model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        longint       sx = $signed(x);
        longint       sy = $signed(y);
        longint       q;
        longint       r;
        logic [63:0]  p;
        exp_t         e;
        m_dz = 1'b0;
        case (op)
            3'd0: begin p = 64'(sx * sy); m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd1: begin p = {32'b0, x} * {32'b0, y}; m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd2, 3'd3: begin
                if (y == '0) begin
                    m_lo = '1; m_hi = x; m_dz = 1'b1;
                end else if (op == 3'd2) begin
                    q = sx / sy; r = sx % sy;
                    m_lo = q[31:0]; m_hi = r[31:0];
                end else begin
                    m_lo = x / y; m_hi = x % y;
                end
            end
            3'd4: m_hi = x;
            3'd5: m_lo = x;
            default: ;
        endcase
        e.hi = m_hi; e.lo = m_lo; e.dz = m_dz;
        sb.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (sb.size() == 0) begin
                check("spurious_done", {63'b0, bus.done}, 64'd0);
            end else begin
                e_pop = sb.pop_front();
                check("res_hi", 64'(bus.hi), 64'(e_pop.hi));
                check("res_lo", 64'(bus.lo), 64'(e_pop.lo));
                check("res_div_zero", 64'(bus.div_zero), 64'(e_pop.dz));
                check("busy_at_done", 64'(bus.busy), 64'd0);
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after edge E0 with inputs scrambled.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        bus.start = 1'b1;
        bus.op    = op;
        bus.op_x  = x;
        bus.op_y  = y;
        model(op, x, y);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 3'($urandom);
        bus.op_x  = $urandom;
        bus.op_y  = $urandom;
    endtask

    // Counts edges until done is seen and how many samples had busy high.
    task automatic wait_done(output int n_edges, output int n_busy);
        n_edges = 0;
        n_busy  = 0;
        forever begin
            if (bus.busy) n_busy++;
            if (bus.done) break;
            if (n_edges >= 200) begin
                check("timeout_done", 64'(bus.done), 64'd1);
                break;
            end
            @(posedge clk);
            #1;
            n_edges++;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_hi"},   64'(bus.hi),       64'd0);
        check({tag, "_lo"},   64'(bus.lo),       64'd0);
        check({tag, "_busy"}, 64'(bus.busy),     64'd0);
        check({tag, "_done"}, 64'(bus.done),     64'd0);
        check({tag, "_dz"},   64'(bus.div_zero), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [2:0]   rop;
        logic [W-1:0] rx;
        logic [W-1:0] ry;
        logic [W-1:0] lo_before;

        bus.start = 1'b0;
        bus.op    = '0;
        bus.op_x  = '0;
        bus.op_y  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("por");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Signed multiply with latency/busy profile, then one-cycle done pulse.
        issue(3'd0, 32'hFFFF_FFFE, 32'd3);
        wait_done(lat, bcnt);
        check("mult_latency", 64'(lat), 64'd33);
        check("mult_busy_cycles", 64'(bcnt), 64'd33);
        @(posedge clk);
        #1;
        check("done_one_cycle", 64'(bus.done), 64'd0);

        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, bcnt);
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat, bcnt);
        check("div_latency", 64'(lat), 64'd33);
        issue(3'd3, 32'd7, 32'd2);
        wait_done(lat, bcnt);

        // Divide by zero, then MTLO back-to-back in the done cycle clears div_zero.
        issue(3'd3, 32'd5, 32'd0);
        wait_done(lat, bcnt);
        check("dz_latency", 64'(lat), 64'd33);
        check("dz_flag", 64'(bus.div_zero), 64'd1);
        issue(3'd5, 32'h0000_0ABC, 32'd0);
        check("b2b_mtlo_lo", 64'(bus.lo), 64'h0ABC);
        check("b2b_mtlo_dz", 64'(bus.div_zero), 64'd0);
        check("b2b_mtlo_done", 64'(bus.done), 64'd1);
        @(posedge clk);
        #1;

        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, bcnt);
        @(posedge clk);
        #1;

        // MTHI: visible right after E0, no busy, lo untouched.
        lo_before = bus.lo;
        issue(3'd4, 32'h0000_1234, 32'd9);
        check("mthi_hi", 64'(bus.hi), 64'h1234);
        check("mthi_lo_kept", 64'(bus.lo), 64'(lo_before));
        check("mthi_busy", 64'(bus.busy), 64'd0);
        check("mthi_done", 64'(bus.done), 64'd1);
        @(posedge clk);
        #1;
        check("mthi_busy_after", 64'(bus.busy), 64'd0);

        // Reserved op is an accepted no-op.
        issue(3'd6, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        wait_done(lat, bcnt);
        check("nop_latency", 64'(lat), 64'd0);
        check("nop_busy", 64'(bcnt), 64'd0);
        @(posedge clk);
        #1;

        // Start at iteration 5 of a MULT is ignored.
        issue(3'd0, 32'h0001_2345, 32'hFFFF_6789);
        repeat (5) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.op    = 3'd4;
        bus.op_x  = 32'hDEAD_0000;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(lat, bcnt);
        check("ignored_start_latency", 64'(lat), 64'd27);
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            rop = 3'($urandom_range(0, 3));
            rx  = $urandom;
            ry  = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            if (i % 2 == 1) ry = -ry;
            issue(rop, rx, ry);
            wait_done(lat, bcnt);
            check("rand_latency", 64'(lat), 64'd33);
        end
        @(posedge clk);
        #1;

        // Reset in the middle of a DIVU aborts it without a done pulse.
        issue(3'd3, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("abort");
        sb.delete();
        m_hi = '0;
        m_lo = '0;
        m_dz = 1'b0;
        @(posedge clk);
        #1;
        check_reset_values("abort_hold");
        rst_n = 1'b1;
        issue(3'd3, 32'd100, 32'd7);
        wait_done(lat, bcnt);
        check("post_reset_latency", 64'(lat), 64'd33);
        check("post_reset_lo", 64'(bus.lo), 64'd14);
        check("post_reset_hi", 64'(bus.hi), 64'd2);
        @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter: WIDTH, default 32, operand and HI/LO register width (legal range 4..64).
REQ-002 SHALL have port: clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  command request, sampled at rising edge of clk.
REQ-005 SHALL have port: op  input  3  command: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op.
REQ-006 SHALL have port: op_x  input  WIDTH  rs operand / dividend / MTHI-MTLO source.
REQ-007 SHALL have port: op_y  input  WIDTH  rt operand / divisor.
REQ-008 SHALL have port: busy  output  1  iterative operation in progress; CPU stalls any HI/LO access while high.
REQ-009 SHALL have port: done  output  1  one-cycle pulse, hi/lo updated.
REQ-010 SHALL have port: hi  output  WIDTH  HI register (product upper half / remainder).
REQ-011 SHALL have port: lo  output  WIDTH  LO register (product lower half / quotient).
REQ-012 SHALL have port: div_zero  output  1  last DIV/DIVU had op_y == 0; sticky until next accepted start.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, DIV, FIX; start is accepted only in IDLE; start while busy is ignored with no side effect.
REQ-014 SHALL latch op, op_x, op_y on the accepting edge E0; later changes to inputs SHALL NOT affect the result.
REQ-015 SHALL, for MULT/MULTU/DIV/DIVU, hold busy=1 from after E0 through edge E(WIDTH+1): WIDTH iteration edges (radix-2 shift-add or restoring subtract), then one FIX edge.
REQ-016 SHALL write hi/lo only at E(WIDTH+1), atomically; at that edge busy falls and done pulses high for exactly one cycle.
REQ-017 SHALL leave hi/lo unchanged during busy; hi/lo hold their values indefinitely between operations.
REQ-018 SHALL compute MULTU as {hi,lo} = unsigned 2*WIDTH-bit product and MULT as the signed two's-complement product.
REQ-019 SHALL operate on magnitudes for signed ops and fix signs in FIX: quotient sign = sign(x) XOR sign(y); remainder sign = sign(x); truncation toward zero.
REQ-020 SHALL return, for DIV with op_x = most-negative and op_y = -1, lo = most-negative and hi = 0 (wrap, no trap).
REQ-021 SHALL, for DIV/DIVU with op_y = 0, use the same latency, write lo = all ones and hi = op_x, and set div_zero=1.
REQ-022 SHALL clear div_zero at every accepted start (including MTHI/MTLO).
REQ-023 SHALL execute MTHI/MTLO in one edge: hi (or lo) <= op_x at E0, other register unchanged, busy never asserted, done pulses in the following cycle.
REQ-024 SHALL treat op 110/111 with start as accepted no-op: no register change, done pulses next cycle.
REQ-025 SHALL accept a new start in the same cycle done is high (back-to-back, FSM already IDLE).

Reset
REQ-026 SHALL, while rst_n=0, asynchronously force hi=0, lo=0, busy=0, done=0, div_zero=0, FSM=IDLE.
REQ-027 SHALL abort an in-flight operation on reset with no hi/lo write and no done pulse; first start after release behaves as from power-up.

Verification (WIDTH=32)
REQ-028 SHALL pass: MULT x=0xFFFFFFFE, y=3 -> busy cycles 1..33, done at edge 33, hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU x=y=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-029 SHALL pass: DIV x=0xFFFFFFF9 (-7), y=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU x=7, y=2 -> lo=3, hi=1.
REQ-030 SHALL pass: DIVU x=5, y=0 -> lo=0xFFFFFFFF, hi=5, div_zero=1; next MTLO start -> div_zero=0.
REQ-031 SHALL pass: DIV x=0x80000000, y=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
REQ-032 SHALL pass: MTHI x=0x1234 -> hi=0x1234 after E0, lo unchanged, busy never high, done next cycle; start with new op at iteration 5 of a MULT -> ignored, MULT result unchanged.
REQ-033 SHALL pass: rst_n low at iteration 10 of a DIVU -> busy/done/hi/lo/div_zero zero immediately (before next clk edge), no done pulse; DIVU 100/7 afterward -> lo=14, hi=2 at edge 33.
